// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM->WB pipeline register.
//   DATA_W / ADDR_W : default write-back data and register address widths
//   ZERO_REG        : architectural zero register, whose writes are never enabled
//   wb_entry_t      : one buffered register-write triple {en, addr, data}
package mem_wb_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned ZERO_REG = 0;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/mem_wb_skid.sv
// Two-entry skid buffer: an OUT entry that drives the outputs and a SKID entry
// that catches one result arriving while the OUT entry is held.
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-low reset
//   in_valid_i / in_data_i  upstream entry offered this cycle
//   in_ready_o              registered; high while the SKID slot is free
//   stall_i                 downstream hold; OUT entry not consumed while high
//   flush_i                 synchronous discard of both entries (highest priority)
//   out_valid_o / out_data_o registered OUT entry
module mem_wb_skid
  import mem_wb_pkg::*;
#(
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid_i,
  input  entry_t in_data_i,
  output logic   in_ready_o,
  input  logic   stall_i,
  input  logic   flush_i,
  output logic   out_valid_o,
  output entry_t out_data_o
);

  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;

  logic accept;
  logic consume;

  assign accept  = in_valid_i & in_ready_q;
  assign consume = out_valid_q & ~stall_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_d        = out_q;
    skid_d       = skid_q;
    if (flush_i) begin
      // Clearing the OUT entry also drops the registered write enable.
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      out_d        = '0;
    end else if (!out_valid_q) begin
      if (accept) begin
        out_valid_d = 1'b1;
        out_d       = in_data_i;
      end
    end else if (!skid_valid_q) begin
      if (consume && accept) begin
        out_d = in_data_i;
      end else if (consume) begin
        out_valid_d = 1'b0;
        out_d       = '0;
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_d       = in_data_i;
      end
    end else if (consume) begin
      // FULL: in_ready is low, so only the drain from SKID into OUT can happen.
      out_d        = skid_q;
      skid_valid_d = 1'b0;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_q;

endmodule

// File: rtl/mem_wb.sv
// MEM->WB pipeline register with a 2-entry skid buffer. Presents the MEM stage's
// register-write triple registered to the regfile write port, one cycle after accept.
// Optional feature macro: MEM_WB_RETIRE_CNT_EN adds CNT_W / retire_cnt_o, a wrapping
// count of committed writes (out_valid_o & write_reg_en_o & !stall_i), kept across flush.
// Ports:
//   clk, rst                       clock (rising edge), asynchronous active-low reset
//   in_valid_i / in_ready_o        upstream handshake (in_ready_o registered)
//   write_reg_{en,addr,data}_i     MEM register-write triple
//   stall_i, flush_i               WB hold, synchronous discard
//   out_valid_o                    output entry valid
//   write_reg_{en,addr,data}_o     registered regfile write port
//   retire_cnt_o                   committed-write count (macro only)
module mem_wb
  import mem_wb_pkg::*;
#(
  parameter int unsigned DATA_W = mem_wb_pkg::DATA_W,
  parameter int unsigned ADDR_W = mem_wb_pkg::ADDR_W
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  parameter int unsigned CNT_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              write_reg_en_i,
  input  logic [ADDR_W-1:0] write_reg_addr_i,
  input  logic [DATA_W-1:0] write_reg_data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  output logic              write_reg_en_o,
  output logic [ADDR_W-1:0] write_reg_addr_o,
  output logic [DATA_W-1:0] write_reg_data_o
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]  retire_cnt_o
`endif
);

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t in_entry;
  entry_t out_entry;

  // Writes to the zero register are turned into bubbles that still keep their slot.
  always_comb begin
    in_entry.en   = write_reg_en_i & (write_reg_addr_i != ADDR_W'(ZERO_REG));
    in_entry.addr = write_reg_addr_i;
    in_entry.data = write_reg_data_i;
  end

  mem_wb_skid #(
    .entry_t(entry_t)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_entry),
    .in_ready_o (in_ready_o),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .out_valid_o(out_valid_o),
    .out_data_o (out_entry)
  );

  assign write_reg_en_o   = out_entry.en;
  assign write_reg_addr_o = out_entry.addr;
  assign write_reg_data_o = out_entry.data;

`ifdef MEM_WB_RETIRE_CNT_EN
  logic             commit;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  assign commit = out_valid_o & write_reg_en_o & ~stall_i;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (commit) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt_o = retire_cnt_q;
`endif

endmodule
